alu_operand_loader: RTL and testbench
=====================================

Name: alu_operand_loader

Overview:
- Upstream front end for the 4-bit ALU datapath on the FPGA board.
- One debounced push button steps a small FSM. On each press the FSM captures the shared 4-bit switch bank as operand A, then operand B, then captures the opcode and carry-in.
- The captured values are held stable on registered outputs that drive the ALU's A, B, Cin and F inputs.
- A one-cycle op_valid pulse marks each newly committed operation.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a button level change is accepted (10 ms at 100 MHz); legal range >= 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived; not overridden).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- btn  input  1  raw step button, asynchronous, bouncy, active-high
- sw  input  4  shared operand switch bank
- sw_f  input  3  opcode switches
- sw_cin  input  1  carry-in switch
- A  output  4  registered operand A to ALU
- B  output  4  registered operand B to ALU
- F  output  3  registered opcode to ALU
- Cin  output  1  registered carry-in to ALU
- op_valid  output  1  one-cycle pulse when F/Cin are committed
- stage  output  2  current FSM state for LEDs: 0=LOAD_A, 1=LOAD_B, 2=LOAD_OP, 3=RUN

Behaviour:
- Reset, asynchronous, rst_n low:
  - A=0, B=0, F=0, Cin=0, op_valid=0, stage=0 (LOAD_A).
  - Synchroniser flops=0, debounced level=0, counter=0.
  - Reset mid-sequence discards all partial captures.
- Synchroniser: btn passes through 2 flops to give btn_s.
- Debouncer:
  - deb holds the accepted level.
  - If btn_s == deb, the counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 while btn_s still differs, deb <= btn_s and the counter clears on the same edge.
  - A bounce shorter than DEBOUNCE_CYCLES never changes deb.
- Press detect: press = deb & ~deb_d, where deb_d is deb delayed one cycle. It is a one-cycle pulse; release generates nothing.
- Latency: a clean press held from edge 0 gives press high in the cycle after edge DEBOUNCE_CYCLES+2. Captures occur on the next edge.
- FSM, advancing only on edges where press=1:
  - LOAD_A -> LOAD_B: A <= sw.
  - LOAD_B -> LOAD_OP: B <= sw.
  - LOAD_OP -> RUN: F <= sw_f, Cin <= sw_cin, op_valid <= 1 for exactly one cycle.
  - RUN -> LOAD_A: A, B, F and Cin keep their old values until overwritten.
- Without a press, all outputs hold. Switch changes never affect outputs except on a capture edge.
- Switches are sampled directly on the capture edge. Switches are quasi-static, so no synchroniser is applied to them.
- op_valid is 0 in every cycle except the one following the LOAD_OP capture edge.
- A held button produces exactly one press; there is no auto-repeat.
- All outputs are registered. There is no combinational path from any input to any output.

Optional Feature:
- Macro: ALU_CHAIN_EN.
- Defined:
  - Adds input port result_in (4 bits, the ALU result from downstream, bits [3:0]).
  - In RUN, a press does A <= result_in and goes to LOAD_B, skipping LOAD_A. This allows accumulator-style chaining.
  - All other transitions are unchanged.
- Undefined:
  - The result_in port is absent.
  - RUN -> LOAD_A as specified above.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: hold rst_n=0 with btn toggling -> A=B=F=Cin=0, op_valid=0, stage=0. Release rst_n -> outputs unchanged.
- Full sequence:
  - Step 1: sw=4'h5, clean press -> A=5, stage=1.
  - Step 2: sw=4'hA, press -> B=A, stage=2.
  - Step 3: sw_f=3'b011, sw_cin=1, press -> F=3, Cin=1, op_valid high exactly 1 cycle, stage=3.
  - Check: A=5 and B=A are unchanged throughout.
- Bounce rejection: btn pulses high 3 cycles, low 2, high 2, low -> no press, stage unchanged. Then hold high 10 cycles -> exactly one advance, first visible DEBOUNCE_CYCLES+3 edges after the stable high begins.
- Hold and release: btn held 50 cycles, then released with 10-cycle release bounce -> exactly one stage advance; nothing on release.
- Reset mid-operation: in LOAD_OP with A=5, B=A, assert rst_n=0 for 1 cycle asynchronously between edges -> all outputs 0 immediately, stage=0. No op_valid pulse.
- Wrap, with and without ALU_CHAIN_EN:
  - Without the macro: in RUN, press -> stage=0, A stays 5 until the next capture.
  - With the macro: result_in=4'hF, press in RUN -> A=F, stage=1.

Source files
------------

// File: rtl/alu_operand_loader_if.sv
// ---------------------------------------------------------------------------
// alu_operand_loader_if : switch/button inputs and registered ALU-side outputs
// Rev 1.0 ; result_in is present only when ALU_CHAIN_EN is defined
// ---------------------------------------------------------------------------
`default_nettype none

interface alu_operand_loader_if;
  logic       btn;
  logic [3:0] sw;
  logic [2:0] sw_f;
  logic       sw_cin;
`ifdef ALU_CHAIN_EN
  logic [3:0] result_in;
`endif
  logic [3:0] A;
  logic [3:0] B;
  logic [2:0] F;
  logic       Cin;
  logic       op_valid;
  logic [1:0] stage;

  modport master (
    input  btn, sw, sw_f, sw_cin,
`ifdef ALU_CHAIN_EN
    input  result_in,
`endif
    output A, B, F, Cin, op_valid, stage
  );

  modport slave (
    output btn, sw, sw_f, sw_cin,
`ifdef ALU_CHAIN_EN
    output result_in,
`endif
    input  A, B, F, Cin, op_valid, stage
  );
endinterface

`default_nettype wire

// File: rtl/alu_operand_loader.sv
// ---------------------------------------------------------------------------
// alu_operand_loader : debounced step button loads A, B, then F/Cin for the ALU
// Rev 1.0 ; optional macro ALU_CHAIN_EN feeds result_in back into A from RUN
// ---------------------------------------------------------------------------
`default_nettype none

module alu_operand_loader #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  alu_operand_loader_if.master  bus
);

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    RUN     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             btn_s;
  logic             deb;
  logic             deb_d;
  logic [CNT_W-1:0] cnt;
  logic             press;

  state_t           state;
  logic [3:0]       a_q;
  logic [3:0]       b_q;
  logic [2:0]       f_q;
  logic             cin_q;
  logic             op_valid_q;

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      btn_s   <= 1'b0;
      deb     <= 1'b0;
      deb_d   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_q1 <= bus.btn;
      btn_s   <= sync_q1;
      deb_d   <= deb;
      if (btn_s == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        deb <= btn_s;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign press = deb & ~deb_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD_A;
      a_q        <= 4'd0;
      b_q        <= 4'd0;
      f_q        <= 3'd0;
      cin_q      <= 1'b0;
      op_valid_q <= 1'b0;
    end else begin
      op_valid_q <= 1'b0;
      if (press) begin
        case (state)
          LOAD_A: begin
            a_q   <= bus.sw;
            state <= LOAD_B;
          end
          LOAD_B: begin
            b_q   <= bus.sw;
            state <= LOAD_OP;
          end
          LOAD_OP: begin
            f_q        <= bus.sw_f;
            cin_q      <= bus.sw_cin;
            op_valid_q <= 1'b1;
            state      <= RUN;
          end
          RUN: begin
`ifdef ALU_CHAIN_EN
            // Accumulator chaining: last ALU result becomes the next A
            a_q   <= bus.result_in;
            state <= LOAD_B;
`else
            state <= LOAD_A;
`endif
          end
          default: state <= LOAD_A;
        endcase
      end
    end
  end

  assign bus.A        = a_q;
  assign bus.B        = b_q;
  assign bus.F        = f_q;
  assign bus.Cin      = cin_q;
  assign bus.op_valid = op_valid_q;
  assign bus.stage    = state;

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_loader.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_loader : scoreboard bench for the button-stepped operand loader
// Rev 1.0 ; run with or without ALU_CHAIN_EN
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_operand_loader;
  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst_n;

  alu_operand_loader_if bus();

  alu_operand_loader #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int fails     = 0;
  int opv_cnt   = 0;
  int opv_run   = 0;
  int opv_max   = 0;

  logic [3:0]  m_a, m_b;
  logic [2:0]  m_f;
  logic        m_cin;
  logic [1:0]  m_stage;
  logic [13:0] sb[$];

  function automatic logic [13:0] observed();
    return {bus.A, bus.B, bus.F, bus.Cin, bus.stage};
  endfunction

  always @(negedge clk) begin
    if (bus.op_valid) begin
      opv_cnt++;
      opv_run++;
    end else begin
      opv_run = 0;
    end
    if (opv_run > opv_max) opv_max = opv_run;
  end

  task automatic model_reset();
    m_a = 4'd0; m_b = 4'd0; m_f = 3'd0; m_cin = 1'b0; m_stage = 2'd0;
    sb.delete();
  endtask

  // Reference behaviour of one accepted press, queued for later comparison
  task automatic push_expected();
    case (m_stage)
      2'd0: begin m_a = bus.sw; m_stage = 2'd1; end
      2'd1: begin m_b = bus.sw; m_stage = 2'd2; end
      2'd2: begin m_f = bus.sw_f; m_cin = bus.sw_cin; m_stage = 2'd3; end
      default: begin
`ifdef ALU_CHAIN_EN
        m_a = bus.result_in; m_stage = 2'd1;
`else
        m_stage = 2'd0;
`endif
      end
    endcase
    sb.push_back({m_a, m_b, m_f, m_cin, m_stage});
  endtask

  task automatic do_press(input int hold, input int rel_bounce, output int lat, output logic opv);
    logic [1:0] st0;
    lat = 0;
    opv = 1'b0;
    @(negedge clk);
    st0 = bus.stage;
    bus.btn = 1'b1;
    for (int i = 1; i <= hold; i++) begin
      @(posedge clk); #1;
      if (lat == 0 && bus.stage !== st0) begin
        lat = i;
        opv = bus.op_valid;
      end
    end
    for (int i = 0; i < rel_bounce; i++) begin
      @(negedge clk);
      bus.btn = (i % 2 == 0) ? 1'b0 : 1'b1;
    end
    @(negedge clk);
    bus.btn = 1'b0;
    repeat (DEB + 8) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [13:0] e;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.btn = 1'($urandom_range(0, 1));
    end
    #1;
    tests_run++;
    if ({observed(), bus.op_valid} !== 15'd0) begin
      fails++;
      $display("FAIL reset_hold: got %h required 0", {observed(), bus.op_valid});
    end
    @(negedge clk);
    bus.btn = 1'b0;
    rst_n = 1'b1;
    model_reset();
    repeat (DEB + 10) @(negedge clk);
    e = {m_a, m_b, m_f, m_cin, m_stage};
    tests_run++;
    if ({observed(), bus.op_valid} !== {e, 1'b0}) begin
      fails++;
      $display("FAIL reset_release: got %h required %h", {observed(), bus.op_valid}, {e, 1'b0});
    end
  endtask

  task automatic test_full_sequence();
    int lat;
    logic opv;
    logic [13:0] e;
    int c0;
    bus.sw = 4'h5;
    push_expected();
    do_press(10, 0, lat, opv);
    e = sb.pop_front();
    tests_run++;
    if (observed() !== e) begin fails++; $display("FAIL load_a: got %h required %h", observed(), e); end

    bus.sw = 4'hA;
    push_expected();
    do_press(10, 0, lat, opv);
    e = sb.pop_front();
    tests_run++;
    if (observed() !== e) begin fails++; $display("FAIL load_b: got %h required %h", observed(), e); end

    bus.sw_f = 3'b011; bus.sw_cin = 1'b1; bus.sw = 4'h3;
    c0 = opv_cnt;
    opv_max = 0;
    push_expected();
    do_press(10, 0, lat, opv);
    e = sb.pop_front();
    tests_run++;
    if (observed() !== e) begin fails++; $display("FAIL load_op: got %h required %h", observed(), e); end
    tests_run++;
    if (opv !== 1'b1) begin fails++; $display("FAIL op_valid_at_commit: got %b required 1", opv); end
    tests_run++;
    if (opv_cnt - c0 != 1 || opv_max != 1) begin
      fails++;
      $display("FAIL op_valid_pulse: got count %0d run %0d required 1 and 1", opv_cnt - c0, opv_max);
    end

    bus.sw = 4'hC; bus.sw_f = 3'b101; bus.sw_cin = 1'b0;
    repeat (10) @(negedge clk);
    tests_run++;
    if (observed() !== {m_a, m_b, m_f, m_cin, m_stage}) begin
      fails++;
      $display("FAIL switch_hold: got %h required %h", observed(), {m_a, m_b, m_f, m_cin, m_stage});
    end
  endtask

  task automatic test_bounce();
    int lat;
    logic opv;
    logic [13:0] e;
    @(negedge clk); bus.btn = 1'b1;
    repeat (3) @(negedge clk);
    bus.btn = 1'b0;
    repeat (2) @(negedge clk);
    bus.btn = 1'b1;
    repeat (2) @(negedge clk);
    bus.btn = 1'b0;
    repeat (12) @(negedge clk);
    tests_run++;
    if (observed() !== {m_a, m_b, m_f, m_cin, m_stage}) begin
      fails++;
      $display("FAIL bounce_reject: got %h required %h", observed(), {m_a, m_b, m_f, m_cin, m_stage});
    end

    push_expected();
    do_press(10, 0, lat, opv);
    e = sb.pop_front();
    tests_run++;
    if (lat != DEB + 3) begin fails++; $display("FAIL press_latency: got %0d required %0d", lat, DEB + 3); end
    tests_run++;
    if (observed() !== e) begin fails++; $display("FAIL bounce_advance: got %h required %h", observed(), e); end
  endtask

  task automatic test_hold_release();
    int lat;
    logic opv;
    logic [13:0] e;
    int c0;
    c0 = opv_cnt;
    bus.sw = 4'h6;
    push_expected();
    do_press(50, 10, lat, opv);
    e = sb.pop_front();
    tests_run++;
    if (observed() !== e) begin fails++; $display("FAIL hold_advance: got %h required %h", observed(), e); end
    repeat (20) @(negedge clk);
    tests_run++;
    if (observed() !== e || opv_cnt != c0) begin
      fails++;
      $display("FAIL no_release_press: got %h opv %0d required %h opv 0", observed(), opv_cnt - c0, e);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic opv;
    logic [13:0] e;
    int c0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    bus.sw = 4'h5;
    push_expected();
    do_press(10, 0, lat, opv);
    void'(sb.pop_front());
    bus.sw = 4'hA;
    push_expected();
    do_press(10, 0, lat, opv);
    e = sb.pop_front();
    tests_run++;
    if (observed() !== e) begin fails++; $display("FAIL reach_load_op: got %h required %h", observed(), e); end

    c0 = opv_cnt;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({observed(), bus.op_valid} !== 15'd0) begin
      fails++;
      $display("FAIL async_reset_now: got %h required 0", {observed(), bus.op_valid});
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (10) @(negedge clk);
    tests_run++;
    if (observed() !== 14'd0 || opv_cnt != c0) begin
      fails++;
      $display("FAIL reset_discard: got %h opv %0d required 0 opv 0", observed(), opv_cnt - c0);
    end
  endtask

  task automatic test_wrap();
    int lat;
    logic opv;
    logic [13:0] e;
    bus.sw = 4'h5;
    push_expected(); do_press(10, 0, lat, opv); void'(sb.pop_front());
    bus.sw = 4'hA;
    push_expected(); do_press(10, 0, lat, opv); void'(sb.pop_front());
    bus.sw_f = 3'b011; bus.sw_cin = 1'b1;
    push_expected(); do_press(10, 0, lat, opv);
    e = sb.pop_front();
    tests_run++;
    if (observed() !== e) begin fails++; $display("FAIL reach_run: got %h required %h", observed(), e); end

`ifdef ALU_CHAIN_EN
    bus.result_in = 4'hF;
`endif
    bus.sw = 4'h9;
    push_expected();
    do_press(10, 0, lat, opv);
    e = sb.pop_front();
    tests_run++;
    if (observed() !== e) begin fails++; $display("FAIL wrap: got %h required %h", observed(), e); end

    bus.sw = 4'h7;
    push_expected();
    do_press(10, 0, lat, opv);
    e = sb.pop_front();
    tests_run++;
    if (observed() !== e) begin fails++; $display("FAIL after_wrap: got %h required %h", observed(), e); end
  endtask

  initial begin
    bus.btn = 1'b0; bus.sw = 4'd0; bus.sw_f = 3'd0; bus.sw_cin = 1'b0;
`ifdef ALU_CHAIN_EN
    bus.result_in = 4'd0;
`endif
    model_reset();
    test_reset();
    test_full_sequence();
    test_bounce();
    test_hold_release();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
